p1_code_sender: RTL and testbench

Sequencer that drives a stored multi-digit combination into the P1 combination lock one digit per clock, then waits for the lock's verdict and reports it. It sits on the lock's digit-entry side, taking the place of manual switch entry, and turns "enter code, read display" into a single start/done transaction for self-test and auto-unlock.

---
 rtl/p1_pkg.sv | 19 +
 rtl/p1_digit_shift.sv | 30 +++
 rtl/p1_code_sender.sv | 145 ++++++++++++++
 tb/tb_p1_code_sender.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/p1_pkg.sv
// Shared definitions for the P1 code sender: FSM states, result codes and the
// default digit width.
package p1_pkg;

    localparam int P1_DIGIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_OPEN    = 2'd1;
    localparam logic [1:0] RES_CLOSED  = 2'd2;
    localparam logic [1:0] RES_TIMEOUT = 2'd3;

endpackage

// File: rtl/p1_digit_shift.sv
// Loadable left-shift register holding the combination; the most-significant
// digit is always presented on top_o.
module p1_digit_shift #(
    parameter int DIGITS  = 6,
    parameter int DIGIT_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_i,
    input  logic                      shift_i,
    input  logic [DIGITS*DIGIT_W-1:0] din_i,
    output logic [DIGIT_W-1:0]        top_o
);
    localparam int W = DIGITS * DIGIT_W;

    logic [W-1:0] sreg_q;

    // Load takes precedence over shift; shifting brings the next digit to the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sreg_q <= '0;
        else if (load_i)
            sreg_q <= din_i;
        else if (shift_i)
            sreg_q <= sreg_q << DIGIT_W;
    end

    assign top_o = sreg_q[W-1 -: DIGIT_W];

endmodule

// File: rtl/p1_code_sender.sv
// Drives a stored combination into the P1 lock one digit per clock, then waits
// for the lock's verdict (open / closed / timeout) and reports it with a
// single-cycle done pulse.
// Build option: define P1_SENDER_GAP_EN to insert one idle cycle between digits.
module p1_code_sender
    import p1_pkg::*;
#(
    parameter int DIGITS  = 6,
    parameter int DIGIT_W = P1_DIGIT_W,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DIGITS*DIGIT_W-1:0] code,
    input  logic                      stat_open,
    input  logic                      stat_closed,
    output logic [DIGIT_W-1:0]        digit_out,
    output logic                      digit_valid,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                result
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);
    localparam logic [7:0]    WAIT_MAX   = 8'(TIMEOUT);

    state_e        state_q;
    logic [CW-1:0] dcnt_q;
    logic [7:0]    wcnt_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
    logic [1:0]    result_q;
    logic          load;
    logic          shift;
    logic [DIGIT_W-1:0] top_digit;
`ifdef P1_SENDER_GAP_EN
    logic          gap_q;
`endif

    assign load = (state_q == S_IDLE) && start;
`ifdef P1_SENDER_GAP_EN
    // Advance on the edge that leaves a valid digit; the gap cycle hides the new top.
    assign shift = (state_q == S_SEND) && !gap_q;
`else
    assign shift = (state_q == S_SEND);
`endif

    p1_digit_shift #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_shift (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .din_i   (code),
        .top_o   (top_digit)
    );

    // Transaction sequencer: IDLE -> SEND -> WAIT -> DONE -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dcnt_q   <= '0;
            wcnt_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= RES_NONE;
`ifdef P1_SENDER_GAP_EN
            gap_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_SEND;
                        dcnt_q   <= '0;
                        wcnt_q   <= '0;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        result_q <= RES_NONE;
`ifdef P1_SENDER_GAP_EN
                        gap_q    <= 1'b0;
`endif
                    end
                end
                S_SEND: begin
`ifdef P1_SENDER_GAP_EN
                    if (gap_q) begin
                        valid_q <= 1'b1;
                        gap_q   <= 1'b0;
                        dcnt_q  <= dcnt_q + 1'b1;
                    end else if (dcnt_q == LAST_DIGIT) begin
                        valid_q <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        valid_q <= 1'b0;
                        gap_q   <= 1'b1;
                    end
`else
                    if (dcnt_q == LAST_DIGIT) begin
                        valid_q <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
`endif
                end
                S_WAIT: begin
                    // Closed wins over open so a confused lock never reads as unlocked.
                    if (stat_closed) begin
                        result_q <= RES_CLOSED;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else if (stat_open) begin
                        result_q <= RES_OPEN;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else if (wcnt_q == WAIT_MAX) begin
                        result_q <= RES_TIMEOUT;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign digit_out   = valid_q ? top_digit : '0;
    assign digit_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;

endmodule

// File: tb/tb_p1_code_sender.sv
// Directed self-checking bench for p1_code_sender (either build of the gap option).
module tb_p1_code_sender;

    localparam int D  = 6;
    localparam int W  = 4;
    localparam int T  = 15;
`ifdef P1_SENDER_GAP_EN
    localparam int NS = 2 * D - 1;
    localparam bit GAP = 1'b1;
`else
    localparam int NS = D;
    localparam bit GAP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [D*W-1:0] code;
    logic           stat_open;
    logic           stat_closed;
    logic [W-1:0]   digit_out;
    logic           digit_valid;
    logic           busy;
    logic           done;
    logic [1:0]     result;

    int nchk = 0;
    int nerr = 0;

    p1_code_sender #(.DIGITS(D), .DIGIT_W(W), .TIMEOUT(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .code        (code),
        .stat_open   (stat_open),
        .stat_closed (stat_closed),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] dig(input logic [D*W-1:0] c, input int idx);
        logic [D*W-1:0] t;
        t = c << (idx * W);
        return t[D*W-1 -: W];
    endfunction

    // Start a transaction and walk the SEND phase, checking each cycle.
    // glitch: pulse start and scramble code mid-SEND; sopen: hold stat_open during SEND.
    task automatic run_send(input logic [D*W-1:0] c, input bit glitch, input bit sopen);
        logic exp_v;
        logic [W-1:0] exp_d;
        code  = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        stat_open = sopen;
        chk("busy_rise", busy, 1);
        chk("result_clr", result, 0);
        for (int i = 0; i < NS; i++) begin
            exp_v = GAP ? (i % 2 == 0) : 1'b1;
            exp_d = exp_v ? dig(c, GAP ? i / 2 : i) : '0;
            chk($sformatf("valid[%0d]", i), digit_valid, exp_v);
            chk($sformatf("digit[%0d]", i), digit_out, exp_d);
            chk($sformatf("done_send[%0d]", i), done, 0);
            if (glitch && i == 2) begin
                start = 1'b1;
                code  = ~c;
            end
            tick();
            start = 1'b0;
        end
        stat_open = 1'b0;
        chk("valid_fall", digit_valid, 0);
        chk("digit_zero", digit_out, 0);
        chk("busy_wait", busy, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; code = '0; stat_open = 1'b0; stat_closed = 1'b0;
        #12;
        chk("rst_digit", digit_out, 0);
        chk("rst_valid", digit_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        reset = 1'b0;
        tick();

        // Open verdict on the second WAIT edge.
        run_send(24'h838482, 1'b0, 1'b0);
        tick();
        chk("t1_nodone", done, 0);
        stat_open = 1'b1;
        tick();
        stat_open = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_result", result, 1);
        chk("t1_busy", busy, 0);
        tick();
        chk("t1_done_fall", done, 0);
        chk("t1_hold", result, 1);

        // Closed verdict two cycles into WAIT.
        run_send(24'h838982, 1'b0, 1'b0);
        tick();
        stat_closed = 1'b1;
        tick();
        stat_closed = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_result", result, 2);
        tick();
        chk("t2_single", done, 0);
        chk("t2_busy", busy, 0);

        // Timeout; stat_open during SEND must be ignored.
        run_send(24'h8384A2, 1'b0, 1'b1);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("t3_edges", n, T + 1);
        chk("t3_result", result, 3);
        tick();

        // Both status lines high: closed wins.
        run_send(24'h838482, 1'b0, 1'b0);
        stat_open = 1'b1; stat_closed = 1'b1;
        tick();
        stat_open = 1'b0; stat_closed = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_result", result, 2);
        tick();

        // start re-pulsed and code changed mid-SEND: no effect.
        run_send(24'h838482, 1'b1, 1'b0);
        stat_open = 1'b1;
        tick();
        stat_open = 1'b0;
        chk("t5_result", result, 1);
        tick();
        tick();
        chk("t5_idle", busy, 0);

        // Reset at the third SEND cycle.
        code  = 24'h838482;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t6_pre_valid", digit_valid, GAP ? 1'b1 : 1'b1);
        chk("t6_pre_digit", digit_out, GAP ? 4'h3 : 4'h8);
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", digit_valid, 0);
        chk("t6_digit", digit_out, 0);
        chk("t6_busy", busy, 0);
        chk("t6_result", result, 0);
        tick();
        chk("t6_done", done, 0);
        reset = 1'b0;
        tick();
        chk("t6_done2", done, 0);
        run_send(24'h838482, 1'b0, 1'b0);
        stat_open = 1'b1;
        tick();
        stat_open = 1'b0;
        chk("t6_after_done", done, 1);
        chk("t6_after_res", result, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
